// File: rtl/dust_pkg.sv
// Shared constants, FSM state encoding and helpers for the dust alarm judge.
package dust_pkg;
  localparam int WIN_DEPTH = 8;
  localparam int WIN_LOG2  = 3;
  localparam int CNT_W     = 10;
  localparam int SUM_W     = 13;
  localparam int REV_W     = 4;

  typedef enum logic [1:0] {
    CLEAN   = 2'd0,
    SUSPECT = 2'd1,
    DIRTY   = 2'd2,
    RECOVER = 2'd3
  } judge_state_e;

  // A programmed revolution count of 0 behaves like 1.
  function automatic logic [REV_W-1:0] eff_revs(input logic [REV_W-1:0] r);
    return (r == '0) ? REV_W'(1) : r;
  endfunction
endpackage

// File: rtl/dust_window_avg.sv
// 8-deep sliding window of per-revolution dust counts with running sum.
// dust_avg and win_full reflect a push on the very next cycle.
module dust_window_avg
  import dust_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [CNT_W-1:0] din,
  output logic [CNT_W-1:0] dust_avg,
  output logic             win_full
);
  logic [WIN_DEPTH-1:0][CNT_W-1:0] win;
  logic [SUM_W-1:0]                sum, sum_nxt;
  logic [WIN_LOG2:0]               fill;

  // Oldest entry is always part of sum, so the subtraction never wraps.
  always_comb sum_nxt = sum + SUM_W'(din) - SUM_W'(win[WIN_DEPTH-1]);

  // Shift window, running sum, registered average and saturating fill count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win      <= '0;
      sum      <= '0;
      dust_avg <= '0;
      fill     <= '0;
    end else if (push) begin
      win      <= {win[WIN_DEPTH-2:0], din};
      sum      <= sum_nxt;
      dust_avg <= sum_nxt[SUM_W-1:WIN_LOG2];
      if (!fill[WIN_LOG2]) fill <= fill + (WIN_LOG2+1)'(1);
    end
  end

  // Fill count saturates at WIN_DEPTH, which is exactly its MSB.
  assign win_full = fill[WIN_LOG2];
endmodule

// File: rtl/dust_alarm_judge.sv
// Revolution-level dust judge: edge detect, delay strobes, window averaging
// and a debounced hysteresis FSM producing an alarm level and event pulses.
module dust_alarm_judge
  import dust_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             zero_flag,
  input  logic [CNT_W-1:0] dust_cnt,
  input  logic             alarm_en,
  input  logic [CNT_W-1:0] set_thresh,
  input  logic [CNT_W-1:0] clr_thresh,
  input  logic [REV_W-1:0] set_revs,
  input  logic [REV_W-1:0] clr_revs,
  output logic [CNT_W-1:0] dust_avg,
  output logic             dust_alarm,
  output logic             alarm_set_pulse,
  output logic             alarm_clr_pulse,
  output logic             win_full
);
  logic             zf_d, rev, act;
  logic [2:1]       vld_pipe;       // [1] = capture strobe, [2] = eval strobe
  judge_state_e     state, state_nxt;
  logic [REV_W-1:0] rev_run, run_nxt, run_inc, set_eff, clr_eff;
  logic             set_nxt, clr_nxt;

  assign rev = zero_flag & ~zf_d;

  // Edge-detect register and revolution strobe pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_d     <= 1'b0;
      vld_pipe <= '0;
    end else begin
      zf_d     <= zero_flag;
      vld_pipe <= {vld_pipe[1], rev};
    end
  end

  dust_window_avg u_win (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (vld_pipe[1]),
    .din      (dust_cnt),
    .dust_avg (dust_avg),
    .win_full (win_full)
  );

  assign act     = vld_pipe[2] & win_full & alarm_en;
  assign set_eff = eff_revs(set_revs);
  assign clr_eff = eff_revs(clr_revs);
  assign run_inc = rev_run + REV_W'(1);

  // Next-state logic; a set pulse marks the alarm rising (CLEAN/SUSPECT ->
  // DIRTY), a clear pulse marks the debounced fall back to CLEAN.
  always_comb begin
    state_nxt = state;
    run_nxt   = rev_run;
    set_nxt   = 1'b0;
    clr_nxt   = 1'b0;
    if (!alarm_en) begin
      state_nxt = CLEAN;
      run_nxt   = '0;
    end else if (act) begin
      unique case (state)
        CLEAN: if (dust_avg >= set_thresh) begin
          if (set_eff == REV_W'(1)) begin
            state_nxt = DIRTY;   run_nxt = '0; set_nxt = 1'b1;
          end else begin
            state_nxt = SUSPECT; run_nxt = REV_W'(1);
          end
        end
        SUSPECT: if (dust_avg >= set_thresh) begin
          if (run_inc >= set_eff) begin
            state_nxt = DIRTY;   run_nxt = '0; set_nxt = 1'b1;
          end else run_nxt = run_inc;
        end else begin
          state_nxt = CLEAN;     run_nxt = '0;
        end
        DIRTY: if (dust_avg <= clr_thresh) begin
          if (clr_eff == REV_W'(1)) begin
            state_nxt = CLEAN;   run_nxt = '0; clr_nxt = 1'b1;
          end else begin
            state_nxt = RECOVER; run_nxt = REV_W'(1);
          end
        end
        RECOVER: if (dust_avg <= clr_thresh) begin
          if (run_inc >= clr_eff) begin
            state_nxt = CLEAN;   run_nxt = '0; clr_nxt = 1'b1;
          end else run_nxt = run_inc;
        end else begin
          state_nxt = DIRTY;     run_nxt = '0;
        end
        default: begin
          state_nxt = CLEAN;     run_nxt = '0;
        end
      endcase
    end
  end

  // FSM state, debounce counter and registered event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= CLEAN;
      rev_run         <= '0;
      alarm_set_pulse <= 1'b0;
      alarm_clr_pulse <= 1'b0;
    end else begin
      state           <= state_nxt;
      rev_run         <= run_nxt;
      alarm_set_pulse <= set_nxt;
      alarm_clr_pulse <= clr_nxt;
    end
  end

  assign dust_alarm = (state == DIRTY) || (state == RECOVER);
endmodule

// File: tb/tb_dust_alarm_judge.sv
// Scoreboard bench for dust_alarm_judge: stimulus pushes expectations from a
// revolution-level model, a negedge monitor pops and compares them.
module tb_dust_alarm_judge;
  logic       clk = 1'b0, rst_n = 1'b1, zero_flag = 1'b0, alarm_en = 1'b0;
  logic [9:0] dust_cnt = '0, set_thresh = '0, clr_thresh = '0, dust_avg;
  logic [3:0] set_revs = '0, clr_revs = '0;
  logic       dust_alarm, alarm_set_pulse, alarm_clr_pulse, win_full;

  typedef struct {int due; int a; int b; int c;} ent_t;

  int   cyc = 0, vectors = 0, errs = 0;
  int   win_q[$];
  int   nrevs = 0, streak = 0;
  bit   m_alarm = 0;
  ent_t avg_q[$], alm_q[$];

  dust_alarm_judge dut (
    .clk(clk), .rst_n(rst_n), .zero_flag(zero_flag), .dust_cnt(dust_cnt),
    .alarm_en(alarm_en), .set_thresh(set_thresh), .clr_thresh(clr_thresh),
    .set_revs(set_revs), .clr_revs(clr_revs), .dust_avg(dust_avg),
    .dust_alarm(dust_alarm), .alarm_set_pulse(alarm_set_pulse),
    .alarm_clr_pulse(alarm_clr_pulse), .win_full(win_full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Monitor: compare whatever expectation falls due on this cycle.
  always @(negedge clk) begin
    ent_t e;
    if (rst_n) begin
      if (avg_q.size() > 0 && avg_q[0].due == cyc) begin
        e = avg_q.pop_front();
        chk("dust_avg", 32'(dust_avg), e.a);
        chk("win_full", 32'(win_full), e.b);
      end
      if (alm_q.size() > 0 && alm_q[0].due == cyc) begin
        e = alm_q.pop_front();
        chk("dust_alarm", 32'(dust_alarm), e.a);
        chk("set_pulse", 32'(alarm_set_pulse), e.b);
        chk("clr_pulse", 32'(alarm_clr_pulse), e.c);
      end else begin
        chk("set_pulse_idle", 32'(alarm_set_pulse), 0);
        chk("clr_pulse_idle", 32'(alarm_clr_pulse), 0);
      end
    end
  end

  // One revolution: model the window average and the debounced alarm.
  task automatic do_rev(input int cnt, input int hold);
    ent_t e;
    int s, eff;
    @(negedge clk);
    zero_flag = 1'b1;
    dust_cnt  = 10'(cnt);
    win_q.push_back(cnt);
    if (win_q.size() > 8) void'(win_q.pop_front());
    nrevs++;
    s = 0;
    foreach (win_q[i]) s += win_q[i];
    e.due = cyc + 2; e.a = s / 8; e.b = (nrevs >= 8); e.c = 0;
    avg_q.push_back(e);
    e.due = cyc + 3; e.b = 0; e.c = 0;
    if (nrevs >= 8 && alarm_en) begin
      if (!m_alarm) begin
        eff = (set_revs == 0) ? 1 : int'(set_revs);
        if (s / 8 >= int'(set_thresh)) begin
          streak++;
          if (streak >= eff) begin m_alarm = 1; streak = 0; e.b = 1; end
        end else streak = 0;
      end else begin
        eff = (clr_revs == 0) ? 1 : int'(clr_revs);
        if (s / 8 <= int'(clr_thresh)) begin
          streak++;
          if (streak >= eff) begin m_alarm = 0; streak = 0; e.c = 1; end
        end else streak = 0;
      end
    end
    e.a = m_alarm;
    alm_q.push_back(e);
    repeat (hold) @(negedge clk);
    zero_flag = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic drop_en();
    ent_t e;
    @(negedge clk);
    alarm_en = 1'b0;
    m_alarm = 0; streak = 0;
    e.due = cyc + 1; e.a = 0; e.b = 0; e.c = 0;
    alm_q.push_back(e);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_dust_avg", 32'(dust_avg), 0);
    chk("rst_dust_alarm", 32'(dust_alarm), 0);
    chk("rst_set_pulse", 32'(alarm_set_pulse), 0);
    chk("rst_clr_pulse", 32'(alarm_clr_pulse), 0);
    chk("rst_win_full", 32'(win_full), 0);
    win_q.delete(); avg_q.delete(); alm_q.delete();
    nrevs = 0; m_alarm = 0; streak = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    do_reset();
    alarm_en = 1'b1; set_thresh = 100; clr_thresh = 20; set_revs = 3; clr_revs = 2;
    repeat (8)  do_rev(0, 1);       // fill window with zeros
    repeat (12) do_rev(200, 1);     // debounced alarm set
    repeat (8)  do_rev(0, 1);       // avg reaches 0 -> recovering
    do_rev(400, 1);                 // avg 50 -> back to dirty, alarm held
    repeat (10) do_rev(0, 1);       // clears via clr_revs path
    repeat (8)  do_rev(1023, 1);    // saturated window, avg 1023
    do_rev(0, 1);                   // avg 895
    do_rev(600, 5);                 // long zero_flag, single push
    drop_en();                      // alarm drops, no clear pulse
    do_rev(300, 1);                 // window still tracks while disabled
    alarm_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_thresh = 10'($urandom_range(100, 700));
      clr_thresh = 10'($urandom_range(0, int'(set_thresh) - 1));
      set_revs   = 4'($urandom_range(0, 4));
      clr_revs   = 4'($urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) begin
        if (alarm_en) drop_en();
      end else alarm_en = 1'b1;
      do_rev(int'($urandom_range(0, 1023)), int'($urandom_range(1, 3)));
    end
    do_reset();
    alarm_en = 1'b1; set_thresh = 100; set_revs = 5;
    repeat (8) do_rev(500, 1);      // first evaluated revolution -> suspect
    do_reset();                     // async reset mid-suspect
    repeat (8) do_rev(0, 1);        // window refills from scratch
    chk("scoreboard_drained", avg_q.size() + alm_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
